// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port memory between three masters.
//   M0 core data port, M1 core fetch port, M2 loader/debug master.
//   Fixed priority M0 > M2 > M1. M1 wins the next arbitration once it has
//   lost STARVE_LIMIT arbitrations in a row. A BUSY phase with no mem_ack_i
//   for TIMEOUT cycles is aborted with a one-cycle err pulse.
// Ports:
//   clk, rst (async, active-low)
//   mN_req_i/we_i/sel_i/addr_i/wdata_i  master N request and payload
//   mN_rdata_o/ack_o/err_o              master N completion (one-cycle pulse)
//   mem_req_o/we_o/sel_o/addr_o/wdata_o memory request and payload
//   mem_rdata_i/ack_i                   memory response
//   hold_flag_o                         fetch is waiting (combinational)

package mem_bus_arbiter_pkg;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned SEL_W  = 4;

  // Request payload latched at arbitration
  typedef struct packed {
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;
endpackage

module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [SEL_W-1:0]  m0_sel_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,

  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [SEL_W-1:0]  m1_sel_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,

  input  logic              m2_req_i,
  input  logic              m2_we_i,
  input  logic [SEL_W-1:0]  m2_sel_i,
  input  logic [ADDR_W-1:0] m2_addr_i,
  input  logic [DATA_W-1:0] m2_wdata_i,
  output logic [DATA_W-1:0] m2_rdata_o,
  output logic              m2_ack_o,
  output logic              m2_err_o,

  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [SEL_W-1:0]  mem_sel_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,

  output logic              hold_flag_o
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q,   state_d;
  logic [1:0]          winner_q,  winner_d;
  mem_cmd_t            cmd_q,     cmd_d;
  logic [STARVE_W-1:0] starve_q,  starve_d;
  logic [TO_W-1:0]     to_q,      to_d;
  logic                mem_req_q, mem_req_d;
  logic [2:0]          ack_q,     ack_d;
  logic [2:0]          err_q,     err_d;
  logic [DATA_W-1:0]   rdata_q [3];
  logic [DATA_W-1:0]   rdata_d [3];

  logic [2:0] req;
  mem_cmd_t   cmd_in [3];

  assign req       = {m2_req_i, m1_req_i, m0_req_i};
  assign cmd_in[0] = {m0_we_i, m0_sel_i, m0_addr_i, m0_wdata_i};
  assign cmd_in[1] = {m1_we_i, m1_sel_i, m1_addr_i, m1_wdata_i};
  assign cmd_in[2] = {m2_we_i, m2_sel_i, m2_addr_i, m2_wdata_i};

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    cmd_d     = cmd_q;
    starve_d  = starve_q;
    to_d      = to_q;
    mem_req_d = 1'b0;
    ack_d     = '0;
    err_d     = '0;
    for (int i = 0; i < 3; i++) rdata_d[i] = '0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          if ((starve_q >= STARVE_W'(STARVE_LIMIT)) && m1_req_i) winner_d = 2'd1;
          else if (m0_req_i)                                       winner_d = 2'd0;
          else if (m2_req_i)                                       winner_d = 2'd2;
          else                                                     winner_d = 2'd1;

          cmd_d = cmd_in[winner_d];

          // Count only arbitrations that fetch actually lost
          if (m1_req_i && (winner_d != 2'd1))
            starve_d = (starve_q >= STARVE_W'(STARVE_LIMIT)) ? STARVE_W'(STARVE_LIMIT)
                                                              : starve_q + STARVE_W'(1);
          else
            starve_d = '0;

          to_d      = '0;
          mem_req_d = 1'b1;
          state_d   = BUSY;
        end
      end

      BUSY: begin
        mem_req_d = 1'b1;
        to_d      = to_q + TO_W'(1);
        // Ack is checked first so an ack on the last allowed cycle is not an error
        if (mem_ack_i) begin
          mem_req_d         = 1'b0;
          to_d              = '0;
          ack_d[winner_q]   = 1'b1;
          rdata_d[winner_q] = cmd_q.we ? '0 : mem_rdata_i;
          state_d           = DONE;
        end else if (to_q == TO_W'(TIMEOUT - 1)) begin
          mem_req_d       = 1'b0;
          to_d            = '0;
          ack_d[winner_q] = 1'b1;
          err_d[winner_q] = 1'b1;
          state_d         = DONE;
        end
      end

      DONE: begin
        to_d    = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      winner_q  <= '0;
      cmd_q     <= '0;
      starve_q  <= '0;
      to_q      <= '0;
      mem_req_q <= 1'b0;
      ack_q     <= '0;
      err_q     <= '0;
      for (int i = 0; i < 3; i++) rdata_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      cmd_q     <= cmd_d;
      starve_q  <= starve_d;
      to_q      <= to_d;
      mem_req_q <= mem_req_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      for (int i = 0; i < 3; i++) rdata_q[i] <= rdata_d[i];
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = cmd_q.we;
  assign mem_sel_o   = cmd_q.sel;
  assign mem_addr_o  = cmd_q.addr;
  assign mem_wdata_o = cmd_q.wdata;

  assign m0_ack_o   = ack_q[0];
  assign m1_ack_o   = ack_q[1];
  assign m2_ack_o   = ack_q[2];
  assign m0_err_o   = err_q[0];
  assign m1_err_o   = err_q[1];
  assign m2_err_o   = err_q[2];
  assign m0_rdata_o = rdata_q[0];
  assign m1_rdata_o = rdata_q[1];
  assign m2_rdata_o = rdata_q[2];

  assign hold_flag_o = m1_req_i & ~ack_q[1];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter with hand-computed expectations.
module tb_mem_bus_arbiter;

  logic        clk, rst;
  logic        m0_req, m0_we, m1_req, m1_we, m2_req, m2_we;
  logic [3:0]  m0_sel, m1_sel, m2_sel;
  logic [31:0] m0_addr, m1_addr, m2_addr, m0_wdata, m1_wdata, m2_wdata;
  logic [31:0] m0_rdata, m1_rdata, m2_rdata;
  logic        m0_ack, m1_ack, m2_ack, m0_err, m1_err, m2_err;
  logic        mem_req, mem_we, mem_ack;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        hold_flag;

  int checks   = 0;
  int failures = 0;

  mem_bus_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_sel_i(m0_sel), .m0_addr_i(m0_addr),
    .m0_wdata_i(m0_wdata), .m0_rdata_o(m0_rdata), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_sel_i(m1_sel), .m1_addr_i(m1_addr),
    .m1_wdata_i(m1_wdata), .m1_rdata_o(m1_rdata), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .m2_req_i(m2_req), .m2_we_i(m2_we), .m2_sel_i(m2_sel), .m2_addr_i(m2_addr),
    .m2_wdata_i(m2_wdata), .m2_rdata_o(m2_rdata), .m2_ack_o(m2_ack), .m2_err_o(m2_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_sel_o(mem_sel), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
    .hold_flag_o(hold_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    {m0_req, m0_we, m1_req, m1_we, m2_req, m2_we} = '0;
    {m0_sel, m1_sel, m2_sel} = '0;
    {m0_addr, m1_addr, m2_addr, m0_wdata, m1_wdata, m2_wdata} = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;

    // Reset state
    tick(); tick();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_acks", 32'({m0_ack, m1_ack, m2_ack}), 32'd0);
    check("rst_hold", 32'(hold_flag), 32'd0);
    rst = 1'b1;
    tick();

    // Single M1 read, minimum latency
    m1_req = 1'b1; m1_addr = 32'h0000_0010;
    #1 check("m1rd_hold_T", 32'(hold_flag), 32'd1);
    tick();
    check("m1rd_mem_req", 32'(mem_req), 32'd1);
    check("m1rd_mem_addr", mem_addr, 32'h0000_0010);
    check("m1rd_mem_we", 32'(mem_we), 32'd0);
    check("m1rd_hold_T1", 32'(hold_flag), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h0013_0093;
    tick();
    check("m1rd_ack", 32'(m1_ack), 32'd1);
    check("m1rd_rdata", m1_rdata, 32'h0013_0093);
    check("m1rd_mem_req_drop", 32'(mem_req), 32'd0);
    check("m1rd_hold_T2", 32'(hold_flag), 32'd0);
    m1_req = 1'b0; mem_ack = 1'b0;
    tick();
    check("m1rd_ack_pulse", 32'(m1_ack), 32'd0);
    check("m1rd_rdata_clr", m1_rdata, 32'd0);

    // M0 write and M1 read on the same cycle: M0 first
    m0_req = 1'b1; m0_we = 1'b1; m0_sel = 4'b0011; m0_addr = 32'h100; m0_wdata = 32'hA5A5_1234;
    m1_req = 1'b1; m1_addr = 32'h10;
    tick();
    check("wr_mem_we", 32'(mem_we), 32'd1);
    check("wr_mem_sel", 32'(mem_sel), 32'h3);
    check("wr_mem_addr", mem_addr, 32'h100);
    check("wr_mem_wdata", mem_wdata, 32'hA5A5_1234);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    check("wr_m0_ack", 32'(m0_ack), 32'd1);
    check("wr_m0_rdata", m0_rdata, 32'd0);
    check("wr_m1_ack", 32'(m1_ack), 32'd0);
    m0_req = 1'b0; m0_we = 1'b0; mem_ack = 1'b0;
    tick();
    check("wr_idle_gap", 32'(mem_req), 32'd0);
    tick();
    check("wr_m1_addr", mem_addr, 32'h10);
    check("wr_m1_we", 32'(mem_we), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    check("wr_m1_ack", 32'(m1_ack), 32'd1);
    check("wr_m1_rdata", m1_rdata, 32'h1111_2222);
    m1_req = 1'b0; mem_ack = 1'b0;
    tick();

    // Starvation: M0 continuous, M1 pending; M1 wins arbitrations 5 and 10
    m0_req = 1'b1; m0_addr = 32'h200;
    m1_req = 1'b1; m1_addr = 32'h300;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("stv_addr_%0d", k), mem_addr, (k % 5 == 0) ? 32'h300 : 32'h200);
      mem_ack = 1'b1; mem_rdata = 32'(k);
      tick();
      check($sformatf("stv_acks_%0d", k), 32'({m1_ack, m0_ack}),
            (k % 5 == 0) ? 32'b10 : 32'b01);
      mem_ack = 1'b0;
      if (k == 10) begin m0_req = 1'b0; m1_req = 1'b0; end
      tick();
    end

    // M2 read with no memory ack: timeout after 16 BUSY cycles
    m2_req = 1'b1; m2_addr = 32'h400;
    tick();
    check("to_mem_req", 32'(mem_req), 32'd1);
    for (int i = 0; i < 15; i++) tick();
    check("to_no_early_ack", 32'(m2_ack), 32'd0);
    check("to_still_busy", 32'(mem_req), 32'd1);
    tick();
    check("to_ack", 32'(m2_ack), 32'd1);
    check("to_err", 32'(m2_err), 32'd1);
    check("to_rdata", m2_rdata, 32'd0);
    m2_req = 1'b0;
    tick();
    check("to_err_pulse", 32'(m2_err), 32'd0);

    // Next M2 request served normally, two-cycle memory latency
    m2_req = 1'b1; m2_addr = 32'h404;
    tick();
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    check("to2_ack", 32'(m2_ack), 32'd1);
    check("to2_err", 32'(m2_err), 32'd0);
    check("to2_rdata", m2_rdata, 32'hCAFE_F00D);
    m2_req = 1'b0; mem_ack = 1'b0;
    tick();

    // Ack on exactly the timeout cycle: ack wins, no error
    m0_req = 1'b1; m0_addr = 32'h500;
    tick();
    for (int i = 0; i < 15; i++) tick();
    check("edge_no_early_ack", 32'(m0_ack), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_C0DE;
    tick();
    check("edge_ack", 32'(m0_ack), 32'd1);
    check("edge_err", 32'(m0_err), 32'd0);
    check("edge_rdata", m0_rdata, 32'h0BAD_C0DE);
    m0_req = 1'b0; mem_ack = 1'b0;
    tick();

    // Async reset during an M0 read drops the transaction
    m0_req = 1'b1; m0_addr = 32'h600;
    tick();
    check("rstb_mem_req", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    m0_req = 1'b0;
    #1;
    check("rstb_mem_req_async", 32'(mem_req), 32'd0);
    check("rstb_mem_addr_async", mem_addr, 32'd0);
    tick();
    rst = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    mem_ack = 1'b0;
    tick();
    check("rstb_no_stale_ack", 32'({m0_ack, m1_ack, m2_ack}), 32'd0);
    check("rstb_idle", 32'(mem_req), 32'd0);

    // Fresh M1 request after reset
    m1_req = 1'b1; m1_addr = 32'h700;
    tick();
    check("rstb_m1_addr", mem_addr, 32'h700);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    check("rstb_m1_ack", 32'(m1_ack), 32'd1);
    check("rstb_m1_rdata", m1_rdata, 32'h1234_5678);
    m1_req = 1'b0; mem_ack = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port data/instruction memory between three masters: core data port (M0, load/store), core fetch port (M1), and the program loader/debug master (M2).
- Sits between open-core memory ports and the RAM.
- Runs fixed priority M0 > M2 > M1, with a starvation guard for fetch and a bus timeout.
- Emits hold_flag_o to the pipeline controller while fetch is waiting.

Parameters:
- STARVE_LIMIT, 4, consecutive lost arbitrations after which M1 wins next arbitration.
- TIMEOUT, 16, cycles in BUSY without mem_ack_i before the transaction is aborted.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- mN_req_i  in  1  request, N=0,1,2; held high until mN_ack_o
- mN_we_i  in  1  1=write, 0=read
- mN_sel_i  in  4  byte enables for writes
- mN_addr_i  in  32  byte address
- mN_wdata_i  in  32  write data
- mN_rdata_o  out  32  read data, valid when mN_ack_o=1
- mN_ack_o  out  1  one-cycle completion pulse
- mN_err_o  out  1  one-cycle timeout pulse, coincident with mN_ack_o
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_sel_o  out  4  memory byte enables
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data
- mem_ack_i  in  1  memory completion, any latency of 1 or more cycles after mem_req_o
- hold_flag_o  out  1  high while m1_req_i=1 and M1 is not granted/acked this cycle

Behaviour:
- Reset (rst=0, async): state=IDLE, starve_cnt=0, to_cnt=0. All outputs are 0, including rdata and mem_* buses. Reset mid-transaction drops the transaction; no ack is issued.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If any req is high, pick the winner and register winner id plus we/sel/addr/wdata. Go to BUSY.
  - In BUSY, mem_req_o=1 and the mem_* buses are driven from registers; mem_req_o rises the cycle after the request is seen.
  - With no request: stay in IDLE, mem_req_o=0.
- Winner selection:
  - If starve_cnt >= STARVE_LIMIT and m1_req_i=1, M1 wins.
  - Otherwise M0, then M2, then M1.
- Starvation counter:
  - starve_cnt increments (saturating at STARVE_LIMIT) on each arbitration M1 loses while m1_req_i=1.
  - Clears when M1 is granted or m1_req_i=0 at arbitration.
- BUSY:
  - to_cnt increments each cycle.
  - If mem_ack_i=1: capture mem_rdata_i (write transaction captures 0), go to DONE, mem_req_o drops the next cycle.
  - Else if to_cnt == TIMEOUT-1: capture 0, set err flag, go to DONE.
  - mem_ack_i and the timeout on the same cycle: the ack wins, no error.
- DONE (exactly one cycle):
  - Winner's mN_ack_o=1 with mN_rdata_o = captured data; mN_err_o=1 if timed out. Other masters' outputs are 0.
  - to_cnt=0, next state is IDLE.
  - Fields are registered, so masters may change inputs the cycle after ack.
- Minimum transaction latency: req seen at cycle T, mem_req_o at T+1, mem_ack_i at T+1 gives mN_ack_o at T+2. Back-to-back grants are separated by one IDLE cycle.
- A requester that drops req while BUSY is still completed: the memory cycle finishes and the ack is issued. Masters must ignore acks they did not expect.
- mem_ack_i outside BUSY is ignored.
- rdata outputs return to 0 in every cycle the matching ack is 0.
- hold_flag_o is combinational: m1_req_i & ~m1_ack_o.

Test Plan:
- Single M1 read, addr 0x0000_0010, memory returns 0x0013_0093 one cycle after mem_req_o → mem_addr_o=0x10 at T+1, m1_ack_o=1 with rdata 0x0013_0093 at T+2, hold_flag_o=1 at T and T+1.
- M0 write (addr 0x100, sel 4'b0011, data 0xA5A5_1234) and M1 read asserted on the same cycle → M0 granted first with mem_we_o=1 and mem_sel_o=4'b0011; M1 granted after M0's DONE+IDLE; m0_rdata_o=0.
- M0 requests continuously with M1 pending and STARVE_LIMIT=4 → M0 gets 4 grants, then M1 is granted on the 5th arbitration, then starve_cnt=0.
- mem_ack_i never asserted on an M2 read with TIMEOUT=16 → at the 16th BUSY cycle m2_ack_o=1, m2_err_o=1, m2_rdata_o=0; the next request is served normally.
- rst pulled low during BUSY of an M0 read → all outputs 0 immediately (async); after rst=1 no stale m0_ack_o appears; a fresh M1 request completes normally.
- mem_ack_i on exactly the timeout cycle (to_cnt=TIMEOUT-1) → ack with captured data, mN_err_o=0.
